// File: rtl/vending_controller_param.sv
// vending_controller_param: N-product vending FSM with stock, credit and chunked change.
// Optional idle-credit auto-return is compiled in with `define VEND_TIMEOUT_EN.
module vending_controller_param #(
  parameter int NUM_PRODUCTS = 4,
  parameter int PROD_W = 2,
  parameter int CREDIT_W = 6,
  parameter int MAX_CREDIT = 31,
  parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICE_LIST =
    {6'd12, 6'd8, 6'd5, 6'd3},
  parameter logic [4*CREDIT_W-1:0] COIN_VAL =
    {6'd10, 6'd5, 6'd2, 6'd1},
  parameter int STOCK_W = 4,
  parameter int INIT_STOCK = 8,
  parameter int CHG_W = 3,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [1:0]              coin,
  input  logic                    coin_insert,
  input  logic                    coin_return,
  input  logic [PROD_W-1:0]       product,
  input  logic                    vend_req,
  input  logic                    restock,
  output logic [PROD_W-1:0]       pro,
  output logic                    pro_valid,
  output logic [CHG_W-1:0]        change,
  output logic                    change_valid,
  output logic [CREDIT_W-1:0]     credit,
  output logic                    coin_reject,
  output logic                    vend_fail,
  output logic [NUM_PRODUCTS-1:0] sold_out,
  output logic                    busy
);

  localparam logic [CREDIT_W-1:0] MAX_CHG =
    CREDIT_W'((1 << CHG_W) - 1);
  localparam logic [STOCK_W-1:0] STOCK_RST = STOCK_W'(INIT_STOCK);
  localparam logic [CREDIT_W:0] CREDIT_LIM = (CREDIT_W+1)'(MAX_CREDIT);

  typedef enum logic [1:0] {
    S_IDLE, S_CREDIT, S_VEND, S_CHANGE
  } state_t;

  state_t state, state_n;

  logic [CREDIT_W-1:0]     credit_n;
  logic [CREDIT_W-1:0]     coin_v;
  logic [CREDIT_W-1:0]     req_price;
  logic [CREDIT_W-1:0]     sel_price;
  logic [CREDIT_W-1:0]     chunk;
  logic [CREDIT_W:0]       coin_sum;
  logic [STOCK_W-1:0]      req_stock;
  logic [PROD_W-1:0]       sel, sel_n, pro_n;
  logic [STOCK_W-1:0]      stock   [NUM_PRODUCTS];
  logic [STOCK_W-1:0]      stock_n [NUM_PRODUCTS];
  logic [NUM_PRODUCTS-1:0] sold_out_n;
  logic [CHG_W-1:0]        change_n;
  logic prod_ok, vend_ok, coin_ok, ret_act, quiet;
  logic pro_valid_n, change_valid_n, busy_n;
  logic coin_reject_n, vend_fail_n;
  logic dec, reload, tmr_hit;

  always_comb begin
    coin_v    = '0;
    req_price = '0;
    sel_price = '0;
    req_stock = '0;
    for (int k = 0; k < 4; k++)
      if (2'(k) == coin)
        coin_v = COIN_VAL[k*CREDIT_W +: CREDIT_W];
    for (int k = 0; k < NUM_PRODUCTS; k++) begin
      if (PROD_W'(k) == product) begin
        req_price = PRICE_LIST[k*CREDIT_W +: CREDIT_W];
        req_stock = stock[k];
      end
      if (PROD_W'(k) == sel)
        sel_price = PRICE_LIST[k*CREDIT_W +: CREDIT_W];
    end
  end

  assign coin_sum = {1'b0, credit} + {1'b0, coin_v};
  assign coin_ok  = enable && (coin_sum <= CREDIT_LIM);
  assign prod_ok  = int'(product) < NUM_PRODUCTS;
  assign vend_ok  = enable && prod_ok && (req_stock != '0) &&
                    (credit >= req_price);
  assign ret_act  = coin_return && (state == S_CREDIT);
  assign quiet    = !coin_insert && !vend_req && !coin_return;
  assign chunk    = (credit > MAX_CHG) ? MAX_CHG : credit;

`ifdef VEND_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] tmr, tmr_n;

  always_comb begin
    tmr_n   = '0;
    tmr_hit = 1'b0;
    if (state == S_CREDIT && quiet) begin
      if (tmr == TMR_W'(TIMEOUT_CYCLES - 1)) tmr_hit = 1'b1;
      else tmr_n = tmr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) tmr <= '0;
    else tmr <= tmr_n;
  end
`else
  assign tmr_hit = 1'b0;
`endif

  always_comb begin
    state_n        = state;
    credit_n       = credit;
    sel_n          = sel;
    pro_n          = pro;
    pro_valid_n    = 1'b0;
    change_n       = change;
    change_valid_n = 1'b0;
    coin_reject_n  = 1'b0;
    vend_fail_n    = 1'b0;
    dec            = 1'b0;
    reload         = 1'b0;
    unique case (state)
      S_IDLE, S_CREDIT: begin
        if (ret_act) begin
          state_n       = S_CHANGE;
          coin_reject_n = coin_insert;
          vend_fail_n   = vend_req;
        end else if (vend_req) begin
          coin_reject_n = coin_insert;
          if (vend_ok) begin
            state_n     = S_VEND;
            sel_n       = product;
            pro_n       = product;
            pro_valid_n = 1'b1;
          end else begin
            vend_fail_n = 1'b1;
          end
        end else if (coin_insert) begin
          if (coin_ok) begin
            credit_n = coin_sum[CREDIT_W-1:0];
            state_n  = S_CREDIT;
          end else begin
            coin_reject_n = 1'b1;
          end
        end else if (tmr_hit) begin
          state_n = S_CHANGE;
        end
        reload = restock && (state == S_IDLE);
      end
      S_VEND: begin
        credit_n      = credit - sel_price;
        dec           = 1'b1;
        state_n       = (credit_n != '0) ? S_CHANGE : S_IDLE;
        coin_reject_n = coin_insert;
        vend_fail_n   = vend_req;
      end
      S_CHANGE: begin
        change_n       = chunk[CHG_W-1:0];
        change_valid_n = 1'b1;
        credit_n       = credit - chunk;
        if (credit_n == '0) state_n = S_IDLE;
        coin_reject_n  = coin_insert;
        vend_fail_n    = vend_req;
      end
      default: state_n = S_IDLE;
    endcase
    busy_n = (state_n == S_VEND) || (state_n == S_CHANGE);
  end

  // stock never wraps; sold_out tracks the post-update counters
  always_comb begin
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      stock_n[i] = stock[i];
      if (reload)
        stock_n[i] = STOCK_RST;
      else if (dec && PROD_W'(i) == sel && stock[i] != '0)
        stock_n[i] = stock[i] - 1'b1;
      sold_out_n[i] = (stock_n[i] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      credit       <= '0;
      sel          <= '0;
      pro          <= '0;
      pro_valid    <= 1'b0;
      change       <= '0;
      change_valid <= 1'b0;
      coin_reject  <= 1'b0;
      vend_fail    <= 1'b0;
      busy         <= 1'b0;
      for (int i = 0; i < NUM_PRODUCTS; i++) begin
        stock[i]    <= STOCK_RST;
        sold_out[i] <= (STOCK_RST == '0);
      end
    end else begin
      state        <= state_n;
      credit       <= credit_n;
      sel          <= sel_n;
      pro          <= pro_n;
      pro_valid    <= pro_valid_n;
      change       <= change_n;
      change_valid <= change_valid_n;
      coin_reject  <= coin_reject_n;
      vend_fail    <= vend_fail_n;
      busy         <= busy_n;
      for (int i = 0; i < NUM_PRODUCTS; i++)
        stock[i] <= stock_n[i];
      sold_out     <= sold_out_n;
    end
  end

endmodule

// File: tb/tb_vending_controller_param.sv
// tb_vending_controller_param: directed plus random ops vs a transaction model.
// Define VEND_TIMEOUT_EN for both bench and RTL to run the auto-return test.
module tb_vending_controller_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic [1:0] coin = '0;
  logic       coin_insert = 1'b0;
  logic       coin_return = 1'b0;
  logic [1:0] product = '0;
  logic       vend_req = 1'b0;
  logic       restock = 1'b0;
  logic [1:0] pro;
  logic       pro_valid;
  logic [2:0] change;
  logic       change_valid;
  logic [5:0] credit;
  logic       coin_reject;
  logic       vend_fail;
  logic [3:0] sold_out;
  logic       busy;

  vending_controller_param dut (
    .clk(clk), .reset(reset), .enable(enable),
    .coin(coin), .coin_insert(coin_insert),
    .coin_return(coin_return), .product(product),
    .vend_req(vend_req), .restock(restock),
    .pro(pro), .pro_valid(pro_valid),
    .change(change), .change_valid(change_valid),
    .credit(credit), .coin_reject(coin_reject),
    .vend_fail(vend_fail), .sold_out(sold_out),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int price [4] = '{3, 5, 8, 12};
  int coinv [4] = '{1, 2, 5, 10};
  int m_credit;
  int m_stock [4];
  int m_pro;

  int exp_rej, exp_fail, exp_pv, exp_pro, exp_n;
  longint exp_sig;
  int obs_rej, obs_fail, obs_pv, obs_pro, obs_n, obs_to;
  longint obs_sig;

  function automatic logic [3:0] m_sold();
    logic [3:0] s;
    for (int i = 0; i < 4; i++) s[i] = (m_stock[i] == 0);
    return s;
  endfunction

  task automatic m_reset();
    m_credit = 0;
    m_pro = 0;
    for (int i = 0; i < 4; i++) m_stock[i] = 8;
  endtask

  task automatic add_chunks(input int r);
    while (r > 0) begin
      int c = (r > 7) ? 7 : r;
      exp_sig = exp_sig * 8 + c;
      exp_n++;
      r -= c;
    end
  endtask

  task automatic model(input bit ci, input int cd, input bit vr,
                       input int p, input bit cr, input bit rs);
    bit idle = (m_credit == 0);
    exp_rej = 0; exp_fail = 0; exp_pv = 0;
    exp_n = 0; exp_sig = 0;
    if (rs && idle)
      for (int i = 0; i < 4; i++) m_stock[i] = 8;
    if (cr && !idle) begin
      exp_rej = ci;
      exp_fail = vr;
      add_chunks(m_credit);
      m_credit = 0;
    end else if (vr) begin
      exp_rej = ci;
      if (enable && m_stock[p] > 0 && m_credit >= price[p]) begin
        exp_pv = 1;
        m_pro = p;
        m_stock[p]--;
        m_credit -= price[p];
        add_chunks(m_credit);
        m_credit = 0;
      end else begin
        exp_fail = 1;
      end
    end else if (ci) begin
      if (enable && m_credit + coinv[cd] <= 31)
        m_credit += coinv[cd];
      else
        exp_rej = 1;
    end
    exp_pro = m_pro;
  endtask

  task automatic op(input bit ci, input bit [1:0] cd, input bit vr,
                    input bit [1:0] p, input bit cr, input bit rs);
    model(ci, int'(cd), vr, int'(p), cr, rs);
    @(negedge clk);
    coin_insert = ci; coin = cd; vend_req = vr;
    product = p; coin_return = cr; restock = rs;
    @(negedge clk);
    coin_insert = 0; vend_req = 0; coin_return = 0; restock = 0;
    obs_rej = coin_reject; obs_fail = vend_fail;
    obs_pv = pro_valid; obs_pro = pro;
    obs_n = 0; obs_sig = 0; obs_to = 1;
    for (int i = 0; i < 64; i++) begin
      if (!busy && !change_valid) begin
        obs_to = 0;
        break;
      end
      @(negedge clk);
      obs_pv += pro_valid;
      if (change_valid) begin
        obs_n++;
        obs_sig = obs_sig * 8 + change;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    m_reset();
    checks++;
    if ({pro, pro_valid, change, change_valid, credit,
         coin_reject, vend_fail, sold_out, busy} !== '0) begin
      failures++;
      $display("FAIL reset: pro=%0d pv=%0d chg=%0d cv=%0d cr=%0d rej=%0d vf=%0d so=%b busy=%0d want all 0",
               pro, pro_valid, change, change_valid, credit,
               coin_reject, vend_fail, sold_out, busy);
    end
  endtask

  task automatic test_basic();
    op(1, 3, 0, 0, 0, 0);
    checks++;
    if (credit !== 6'd10) begin
      failures++;
      $display("FAIL basic_coin10: credit=%0d want 10", credit);
    end
    op(1, 1, 0, 0, 0, 0);
    checks++;
    if (credit !== 6'd12) begin
      failures++;
      $display("FAIL basic_coin2: credit=%0d want 12", credit);
    end
    op(0, 0, 1, 0, 0, 0);
    checks++;
    if (obs_pv !== 1 || obs_pro !== 0 || obs_n !== 2 ||
        obs_sig !== 58 || credit !== 0 || busy !== 0 || obs_to) begin
      failures++;
      $display("FAIL basic_vend: pv=%0d pro=%0d n=%0d sig=%0d cr=%0d busy=%0d want 1 0 2 58 0 0",
               obs_pv, obs_pro, obs_n, obs_sig, credit, busy);
    end
  endtask

  task automatic test_saturate();
    repeat (3) op(1, 3, 0, 0, 0, 0);
    op(1, 1, 0, 0, 0, 0);
    checks++;
    if (obs_rej !== 1 || credit !== 6'd30) begin
      failures++;
      $display("FAIL sat_reject: rej=%0d cr=%0d want 1 30",
               obs_rej, credit);
    end
    op(0, 0, 0, 0, 1, 0);
    checks++;
    if (obs_n !== 5 || obs_sig !== 32762 || credit !== 0 || obs_to) begin
      failures++;
      $display("FAIL sat_return: n=%0d sig=%0d cr=%0d want 5 32762 0",
               obs_n, obs_sig, credit);
    end
  endtask

  task automatic test_refuse();
    op(1, 2, 0, 0, 0, 0);
    op(0, 0, 1, 3, 0, 0);
    checks++;
    if (obs_fail !== 1 || obs_pv !== 0 || credit !== 6'd5) begin
      failures++;
      $display("FAIL refuse_price: vf=%0d pv=%0d cr=%0d want 1 0 5",
               obs_fail, obs_pv, credit);
    end
    op(0, 0, 1, 1, 0, 0);
    checks++;
    if (obs_pv !== 1 || obs_pro !== 1 || obs_n !== 0 || credit !== 0) begin
      failures++;
      $display("FAIL refuse_exact: pv=%0d pro=%0d n=%0d cr=%0d want 1 1 0 0",
               obs_pv, obs_pro, obs_n, credit);
    end
  endtask

  task automatic test_sold_out();
    for (int i = 0; i < 8; i++) begin
      op(1, 3, 0, 0, 0, 0);
      op(0, 0, 1, 2, 0, 0);
      checks++;
      if (obs_pv !== 1 || obs_pro !== 2 || obs_sig !== 2) begin
        failures++;
        $display("FAIL sold_vend%0d: pv=%0d pro=%0d sig=%0d want 1 2 2",
                 i, obs_pv, obs_pro, obs_sig);
      end
    end
    checks++;
    if (sold_out !== 4'b0100) begin
      failures++;
      $display("FAIL sold_flag: so=%b want 0100", sold_out);
    end
    op(1, 3, 0, 0, 0, 0);
    op(0, 0, 1, 2, 0, 0);
    checks++;
    if (obs_fail !== 1 || obs_pv !== 0 || credit !== 6'd10) begin
      failures++;
      $display("FAIL sold_ninth: vf=%0d pv=%0d cr=%0d want 1 0 10",
               obs_fail, obs_pv, credit);
    end
    op(0, 0, 0, 0, 0, 1);
    checks++;
    if (sold_out !== 4'b0100) begin
      failures++;
      $display("FAIL restock_credit: so=%b want 0100", sold_out);
    end
    op(0, 0, 0, 0, 1, 0);
    op(0, 0, 0, 0, 0, 1);
    checks++;
    if (sold_out !== 4'b0000) begin
      failures++;
      $display("FAIL restock_idle: so=%b want 0000", sold_out);
    end
  endtask

  task automatic test_priority();
    op(1, 3, 0, 0, 0, 0);
    op(1, 0, 1, 0, 0, 0);
    checks++;
    if (obs_rej !== 1 || obs_pv !== 1 || obs_pro !== 0 ||
        obs_n !== 1 || obs_sig !== 7 || credit !== 0) begin
      failures++;
      $display("FAIL priority: rej=%0d pv=%0d pro=%0d n=%0d sig=%0d cr=%0d want 1 1 0 1 7 0",
               obs_rej, obs_pv, obs_pro, obs_n, obs_sig, credit);
    end
  endtask

  task automatic test_enable();
    enable = 0;
    op(1, 3, 0, 0, 0, 0);
    checks++;
    if (obs_rej !== 1 || credit !== 0) begin
      failures++;
      $display("FAIL enable_coin: rej=%0d cr=%0d want 1 0",
               obs_rej, credit);
    end
    enable = 1;
    op(1, 3, 0, 0, 0, 0);
    enable = 0;
    op(0, 0, 1, 0, 0, 0);
    checks++;
    if (obs_fail !== 1 || credit !== 6'd10) begin
      failures++;
      $display("FAIL enable_vend: vf=%0d cr=%0d want 1 10",
               obs_fail, credit);
    end
    enable = 1;
    op(0, 0, 0, 0, 1, 0);
  endtask

  task automatic test_reset_change();
    repeat (3) op(1, 3, 0, 0, 0, 0);
    @(negedge clk);
    coin_return = 1;
    @(negedge clk);
    coin_return = 0;
    @(negedge clk);
    checks++;
    if (change_valid !== 1 || busy !== 1) begin
      failures++;
      $display("FAIL rst_chg_pre: cv=%0d busy=%0d want 1 1",
               change_valid, busy);
    end
    reset = 1;
    @(negedge clk);
    reset = 0;
    m_reset();
    checks++;
    if (credit !== 0 || change_valid !== 0 || busy !== 0) begin
      failures++;
      $display("FAIL rst_chg: cr=%0d cv=%0d busy=%0d want 0 0 0",
               credit, change_valid, busy);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 300; t++) begin
      int r = $urandom_range(0, 19);
      bit ci = 0, vr = 0, cr = 0, rs = 0;
      bit [1:0] cd = 2'($urandom_range(0, 3));
      bit [1:0] p = 2'($urandom_range(0, 3));
      enable = ($urandom_range(0, 9) != 0);
      if (r < 9) ci = 1;
      else if (r < 15) begin
        vr = 1;
        ci = (r == 14);
      end else if (r < 17) begin
        cr = 1;
        ci = (r == 16);
      end else rs = 1;
      op(ci, cd, vr, p, cr, rs);
      checks++;
      if (obs_rej !== exp_rej || obs_fail !== exp_fail ||
          obs_pv !== exp_pv || (exp_pv && obs_pro !== exp_pro) ||
          obs_n !== exp_n || obs_sig !== exp_sig || obs_to ||
          credit !== 6'(m_credit) || sold_out !== m_sold()) begin
        failures++;
        $display("FAIL rand%0d: rej=%0d/%0d vf=%0d/%0d pv=%0d/%0d pro=%0d/%0d n=%0d/%0d sig=%0d/%0d cr=%0d/%0d so=%b/%b to=%0d",
                 t, obs_rej, exp_rej, obs_fail, exp_fail,
                 obs_pv, exp_pv, obs_pro, exp_pro, obs_n, exp_n,
                 obs_sig, exp_sig, credit, m_credit,
                 sold_out, m_sold(), obs_to);
      end
    end
    enable = 1;
  endtask

`ifdef VEND_TIMEOUT_EN
  task automatic test_timeout();
    int got = 0;
    op(0, 0, 0, 0, 1, 0);
    op(1, 2, 0, 0, 0, 0);
    for (int i = 0; i < 1100 && !(got > 0 && credit == 0); i++) begin
      @(negedge clk);
      if (change_valid) got += change;
    end
    m_credit = 0;
    checks++;
    if (got !== 5 || credit !== 0) begin
      failures++;
      $display("FAIL timeout: returned=%0d cr=%0d want 5 0",
               got, credit);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_refuse();
    test_sold_out();
    test_priority();
    test_enable();
    test_reset_change();
    test_random();
`ifdef VEND_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vending_controller_param.md
Name: vending_controller_param

Overview:
- Parametrised successor to the fixed 4-product vending controller.
- Supports N products with per-product prices and per-product stock counters.
- Accepts coins from a 4-code coin acceptor with credit saturation, and returns change over multiple cycles in bounded chunks.
- Sits between the coin acceptor / keypad front end and the dispenser / change-hopper drivers.

Parameters:
NUM_PRODUCTS, 4, number of selectable products (>=2)
PROD_W, 2, width of product index, = clog2(NUM_PRODUCTS)
CREDIT_W, 6, width of credit accumulator and of each price/coin value
MAX_CREDIT, 31, highest credit value accepted; a coin that would exceed it is rejected
PRICE_LIST, {6'd12,6'd8,6'd5,6'd3}, packed prices, product i at bits [i*CREDIT_W +: CREDIT_W]
COIN_VAL, {6'd10,6'd5,6'd2,6'd1}, packed values for coin codes 0..3
STOCK_W, 4, width of each stock counter
INIT_STOCK, 8, stock loaded into every product at reset and on restock
CHG_W, 3, width of change output; maximum change per cycle is 2^CHG_W-1
TIMEOUT_CYCLES, 1000, idle limit before auto-return (optional feature only)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  machine enabled; when low, coins are rejected and vend requests fail
coin  input  2  coin code, valid with coin_insert
coin_insert  input  1  one coin presented this cycle
coin_return  input  1  request return of all credit
product  input  PROD_W  product index, valid with vend_req
vend_req  input  1  vend request for product
restock  input  1  reload all stock counters to INIT_STOCK
pro  output  PROD_W  dispensed product index
pro_valid  output  1  one-cycle dispense strobe
change  output  CHG_W  change amount this cycle
change_valid  output  1  change strobe
credit  output  CREDIT_W  current credit
coin_reject  output  1  one-cycle pulse, presented coin not accepted
vend_fail  output  1  one-cycle pulse, vend request refused
sold_out  output  NUM_PRODUCTS  bit i high when stock[i]==0
busy  output  1  high in VEND or CHANGE

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - state=IDLE, credit=0, all stock=INIT_STOCK.
  - pro=0, pro_valid=0, change=0, change_valid=0.
  - coin_reject=0, vend_fail=0, busy=0, sold_out=0 (if INIT_STOCK>0).
- States: IDLE (credit==0), CREDIT (credit>0), VEND, CHANGE.
- Input priority each cycle in IDLE/CREDIT: coin_return > vend_req > coin_insert. A coin that loses priority gets coin_reject the next cycle.
- Coin accept:
  - If enable=1 and credit+COIN_VAL[coin] <= MAX_CREDIT, credit updates at the next edge and the state goes to CREDIT.
  - Otherwise coin_reject pulses for one cycle and credit is unchanged.
  - Sum is computed at CREDIT_W+1 bits so it cannot wrap.
- Vend request in IDLE/CREDIT:
  - Refused if enable=0, product>=NUM_PRODUCTS, stock[product]==0, or credit<price. On refusal, vend_fail pulses the next cycle and state is unchanged.
  - Otherwise go to VEND, latching product.
- VEND (exactly one cycle):
  - pro=latched index, pro_valid=1.
  - credit -= price, stock decrements.
  - Next state is CHANGE if the remaining credit>0, else IDLE.
  - pro_valid appears 1 cycle after the accepted vend_req edge; pro holds its last value when pro_valid=0.
- coin_return: in CREDIT goes to CHANGE; in IDLE it is ignored.
- CHANGE:
  - Each cycle, change=min(credit, 2^CHG_W-1), change_valid=1, credit decreases by the same amount.
  - On the cycle credit reaches 0, go to IDLE.
  - Example: credit 17, CHG_W=3 → 7,7,3 over 3 cycles.
- In VEND/CHANGE: coins get coin_reject, vend_req gets vend_fail, coin_return is ignored.
- restock: accepted only in IDLE (stock=INIT_STOCK next edge); ignored in any other state.
- sold_out is updated in the same edge as the stock change.
- Stock counters never wrap below 0; a vend is refused at 0.
- Reset mid-VEND or mid-CHANGE: all state and credit are cleared and any remaining change is forfeited. This is intended; the hopper driver is reset by the same signal.

Optional Feature:
VEND_TIMEOUT_EN:
- Defined: a counter in CREDIT counts cycles with no coin_insert/vend_req/coin_return. When it reaches TIMEOUT_CYCLES, the block enters CHANGE and returns all credit. The counter clears on any such input and on leaving CREDIT.
- Undefined: credit is held indefinitely; no counter logic.

Test Plan:
- Reset, insert coin code 3 (10) then code 1 (2), vend product 0 (price 3) → credit 10, then 12; pro_valid with pro=0; change 7 then 2; credit 0; IDLE.
- Credit 30, insert code 1 (2) → coin_reject pulse, credit stays 30; coin_return → change 7,7,7,7,2 then idle.
- Credit 5, vend product 3 (price 12) → vend_fail, credit 5. Then vend product 1 (price 5) → pro=1, no change cycles.
- Vend product 2 eight times with sufficient credit → sold_out[2]=1 and the ninth vend fails; restock in IDLE → sold_out[2]=0, stock 8.
- Same cycle coin_insert and vend_req (credit sufficient) → vend accepted, coin_reject pulse. Assert reset during CHANGE → credit 0, change_valid 0 next cycle.
- With VEND_TIMEOUT_EN, TIMEOUT_CYCLES=20: insert 5, idle 20 cycles → change 5, state IDLE.
